// File: rtl/miriscv_arb_pkg.sv
// Shared types and limits for the fetch/LSU memory arbiter.
package miriscv_arb_pkg;

   // Requester identity, stored per outstanding transaction.
   typedef enum logic {
      ARB_ID_INSTR = 1'b0,
      ARB_ID_DATA  = 1'b1
   } arb_id_e;

   // Upper bound on the outstanding-transaction depth.
   localparam int unsigned ARB_MAX_OUTSTANDING_MAX = 8;

   // Arbitration choice when both sides request and nothing is held.
   function automatic arb_id_e arb_pick_contended(input logic    round_robin,
                                                  input arb_id_e last_grant);
      arb_id_e w_pick;
      if (round_robin) begin
         w_pick = (last_grant == ARB_ID_INSTR) ? ARB_ID_DATA : ARB_ID_INSTR;
      end else begin
         w_pick = ARB_ID_DATA;
      end
      return w_pick;
   endfunction

endpackage : miriscv_arb_pkg

// File: rtl/miriscv_arb_id_fifo.sv
// In-order FIFO of requester IDs for transactions accepted by memory but not
// yet answered. Depth need not be a power of two; pointers wrap explicitly.
module miriscv_arb_id_fifo
   import miriscv_arb_pkg::*;
#(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk_i,
   input  logic             arstn_i,
   input  logic             push_i,
   input  arb_id_e          push_id_i,
   input  logic             pop_i,
   output arb_id_e          head_o,
   output logic [CNT_W-1:0] count_o,
   output logic             empty_o,
   output logic             full_o
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
   localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);

   arb_id_e          r_mem [DEPTH];
   logic [PTR_W-1:0] r_wptr;
   logic [PTR_W-1:0] r_rptr;
   logic [CNT_W-1:0] r_count;

   logic w_empty;
   logic w_full;
   logic w_push;
   logic w_pop;

   // Advance a pointer, wrapping at DEPTH-1 regardless of pointer width.
   function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
      logic [PTR_W-1:0] w_nxt;
      if (ptr == LAST_PTR) begin
         w_nxt = {PTR_W{1'b0}};
      end else begin
         w_nxt = ptr + PTR_W'(1);
      end
      return w_nxt;
   endfunction

   assign w_empty = (r_count == {CNT_W{1'b0}});
   assign w_full  = (r_count == DEPTH_CNT);
   assign w_pop   = pop_i & ~w_empty;
   assign w_push  = push_i & ~w_full;

   // Storage: write the pushed ID at the write pointer.
   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            r_mem[i] <= ARB_ID_INSTR;
         end
      end else if (w_push) begin
         r_mem[r_wptr] <= push_id_i;
      end
   end

   // Pointers and occupancy; a simultaneous push and pop leaves count unchanged.
   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         r_wptr  <= {PTR_W{1'b0}};
         r_rptr  <= {PTR_W{1'b0}};
         r_count <= {CNT_W{1'b0}};
      end else begin
         if (w_push) begin
            r_wptr <= ptr_next(r_wptr);
         end
         if (w_pop) begin
            r_rptr <= ptr_next(r_rptr);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign head_o  = r_mem[r_rptr];
   assign count_o = r_count;
   assign empty_o = w_empty;
   assign full_o  = w_full;

endmodule : miriscv_arb_id_fifo

// File: rtl/miriscv_mem_arbiter.sv
// Shares one single-port memory between instruction fetch and the LSU.
// Requests and responses pass through with zero added latency; the ID FIFO
// remembers who issued each outstanding transaction so in-order responses
// can be routed back.
module miriscv_mem_arbiter
   import miriscv_arb_pkg::*;
#(
   parameter int unsigned XLEN            = 32,
   parameter int unsigned MAX_OUTSTANDING = 2,
   parameter bit          ROUND_ROBIN     = 1'b1
) (
   input  logic              clk_i,
   input  logic              arstn_i,
   input  logic              instr_req_i,
   input  logic [XLEN-1:0]   instr_addr_i,
   output logic              instr_gnt_o,
   output logic              instr_rvalid_o,
   output logic [XLEN-1:0]   instr_rdata_o,
   input  logic              data_req_i,
   input  logic              data_we_i,
   input  logic [XLEN/8-1:0] data_be_i,
   input  logic [XLEN-1:0]   data_addr_i,
   input  logic [XLEN-1:0]   data_wdata_i,
   output logic              data_gnt_o,
   output logic              data_rvalid_o,
   output logic [XLEN-1:0]   data_rdata_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [XLEN/8-1:0] mem_be_o,
   output logic [XLEN-1:0]   mem_addr_o,
   output logic [XLEN-1:0]   mem_wdata_o,
   input  logic              mem_gnt_i,
   input  logic              mem_rvalid_i,
   input  logic [XLEN-1:0]   mem_rdata_i,
   output logic              spurious_rsp_o
);

   localparam int unsigned BE_W  = XLEN / 8;
   localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

   arb_id_e r_last_grant;
   logic    r_hold_valid;
   arb_id_e r_hold_sel;

   arb_id_e          w_sel;
   arb_id_e          w_head;
   logic [CNT_W-1:0] w_count;
   logic             w_fifo_empty;
   logic             w_fifo_full;
   logic             w_can_issue;
   logic             w_req;
   logic             w_xfer;
   logic             w_pop;

   // Occupancy comes from registered state only, so a response in this cycle
   // never frees a slot for a request in the same cycle.
   assign w_can_issue = ~w_fifo_full & (w_count < MAX_CNT);
   assign w_req       = w_can_issue & (instr_req_i | data_req_i);
   assign w_xfer      = w_req & mem_gnt_i;
   assign w_pop       = mem_rvalid_i & ~w_fifo_empty;

   // Requester selection: a held selection wins, otherwise arbitrate.
   always_comb begin
      w_sel = ARB_ID_INSTR;
      if (r_hold_valid) begin
         w_sel = r_hold_sel;
      end else if (instr_req_i && data_req_i) begin
         w_sel = arb_pick_contended(ROUND_ROBIN, r_last_grant);
      end else if (data_req_i) begin
         w_sel = ARB_ID_DATA;
      end else begin
         w_sel = ARB_ID_INSTR;
      end
   end

   // Hold a stalled selection until memory accepts it; kept while full.
   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         r_hold_valid <= 1'b0;
         r_hold_sel   <= ARB_ID_INSTR;
      end else if (w_req && !mem_gnt_i) begin
         r_hold_valid <= 1'b1;
         r_hold_sel   <= w_sel;
      end else if (w_xfer) begin
         r_hold_valid <= 1'b0;
         r_hold_sel   <= ARB_ID_INSTR;
      end
   end

   // Remember the last granted side for round-robin fairness.
   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         r_last_grant <= ARB_ID_INSTR;
      end else if (w_xfer) begin
         r_last_grant <= w_sel;
      end
   end

   miriscv_arb_id_fifo #(
      .DEPTH (MAX_OUTSTANDING),
      .CNT_W (CNT_W)
   ) u_id_fifo (
      .clk_i     (clk_i),
      .arstn_i   (arstn_i),
      .push_i    (w_xfer),
      .push_id_i (w_sel),
      .pop_i     (w_pop),
      .head_o    (w_head),
      .count_o   (w_count),
      .empty_o   (w_fifo_empty),
      .full_o    (w_fifo_full)
   );

   // Output mux and response routing; everything reads zero while in reset.
   always_comb begin
      mem_req_o      = 1'b0;
      mem_we_o       = 1'b0;
      mem_be_o       = {BE_W{1'b0}};
      mem_addr_o     = {XLEN{1'b0}};
      mem_wdata_o    = {XLEN{1'b0}};
      instr_gnt_o    = 1'b0;
      data_gnt_o     = 1'b0;
      instr_rvalid_o = 1'b0;
      data_rvalid_o  = 1'b0;
      instr_rdata_o  = {XLEN{1'b0}};
      data_rdata_o   = {XLEN{1'b0}};
      spurious_rsp_o = 1'b0;
      if (arstn_i) begin
         mem_req_o = w_req;
         case (w_sel)
            ARB_ID_DATA: begin
               mem_we_o    = data_we_i;
               mem_be_o    = data_be_i;
               mem_addr_o  = data_addr_i;
               mem_wdata_o = data_wdata_i;
               data_gnt_o  = w_xfer;
            end
            ARB_ID_INSTR: begin
               mem_we_o    = 1'b0;
               mem_be_o    = {BE_W{1'b1}};
               mem_addr_o  = instr_addr_i;
               mem_wdata_o = {XLEN{1'b0}};
               instr_gnt_o = w_xfer;
            end
            default: begin
               mem_we_o    = 1'b0;
               mem_be_o    = {BE_W{1'b0}};
               mem_addr_o  = {XLEN{1'b0}};
               mem_wdata_o = {XLEN{1'b0}};
            end
         endcase
         instr_rdata_o  = mem_rdata_i;
         data_rdata_o   = mem_rdata_i;
         instr_rvalid_o = w_pop & (w_head == ARB_ID_INSTR);
         data_rvalid_o  = w_pop & (w_head == ARB_ID_DATA);
         spurious_rsp_o = mem_rvalid_i & w_fifo_empty;
      end else begin
         mem_req_o = 1'b0;
      end
   end

endmodule : miriscv_mem_arbiter
